// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int UART_FRAME_CYC = 11;
  localparam int WD_CYC_DEFAULT = 4;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: the search starts one past the last winner and wraps.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  logic [ID_W-1:0] cand_s;
  logic            hit_s;

  // Walk the candidates in priority order; the first valid one latches the grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s         = ID_W'((int'(last) + k) % NUM_REQ);
      hit_s          = ~any & req_valid[cand_s];
      grant[cand_s]  = grant[cand_s] | hit_s;
      grant_idx      = hit_s ? cand_s : grant_idx;
      any            = any | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Optional start watchdog enabled by defining UART_TX_ARB_WATCHDOG_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int WD_CYC  = WD_CYC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active,
  output logic                 wd_err
);

  arb_state_t state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            active_q, active_d;
  logic            wd_err_q, wd_err_d;

  logic [NUM_REQ-1:0] pick_grant_s;
  logic [ID_W-1:0]    pick_idx_s;
  logic               pick_any_s;
  logic [7:0]         sel_byte_s;

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYC + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .last      (last_q),
    .grant     (pick_grant_s),
    .grant_idx (pick_idx_s),
    .any       (pick_any_s)
  );

  // One-hot grant lets the byte mux be a plain AND-OR.
  always_comb begin
    sel_byte_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_byte_s = sel_byte_s | (req_data[8*i +: 8] & {8{pick_grant_s[i]}});
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    active_d   = active_q;
    req_ready  = '0;
`ifdef UART_TX_ARB_WATCHDOG_EN
    wd_err_d   = wd_err_q;
    wd_cnt_d   = '0;
`else
    wd_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        req_ready = rst ? '0 : pick_grant_s;
        if (pick_any_s) begin
          tx_data_d  = sel_byte_s;
          tx_start_d = 1'b1;
          grant_id_d = pick_idx_s;
          last_d     = pick_idx_s;
          active_d   = 1'b1;
          state_d    = WAIT_BUSY;
        end else begin
          state_d    = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
`ifdef UART_TX_ARB_WATCHDOG_EN
        else if (wd_cnt_q == WD_W'(WD_CYC - 1)) begin
          state_d  = IDLE;
          active_d = 1'b0;
          wd_err_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`else
        else begin
          state_d = WAIT_BUSY;
        end
`endif
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d  = WAIT_DONE;
        end
      end
      default: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= ID_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      active_q   <= 1'b0;
      wd_err_q   <= 1'b0;
`ifdef UART_TX_ARB_WATCHDOG_EN
      wd_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      active_q   <= active_d;
      wd_err_q   <= wd_err_d;
`ifdef UART_TX_ARB_WATCHDOG_EN
      wd_cnt_q   <= wd_cnt_d;
`endif
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign active   = active_q;
  assign wd_err   = wd_err_q;

endmodule
